// File: rtl/serial_sum_sched.sv
// Scheduler and clock master for the bit-serial adder: bclk/lrclk generation,
// round-robin operand issue (one op per frame) and tagged result return.
module serial_sum_sched #(
   parameter int unsigned W          = 32,
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FRAME_BITS = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [2*N_REQ-1:0]         req_op,
   input  logic [W*N_REQ-1:0]         req_a,
   input  logic [W*N_REQ-1:0]         req_b,
   output logic                       bclk,
   output logic                       lrclk,
   output logic                       ser_a,
   output logic                       ser_b,
   output logic                       minus_a,
   output logic                       minus_b,
   input  logic [W-1:0]               res_p,
   output logic                       rsp_valid,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [W-1:0]               rsp_data,
   output logic                       busy
);

   localparam int unsigned ID_W   = $clog2(N_REQ);
   localparam int unsigned DIV_W  = $clog2(CLK_DIV);
   localparam int unsigned SLOT_W = $clog2(FRAME_BITS);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_BITS - 1);
   localparam logic [SLOT_W-1:0] SLOT_MSB  = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] SLOT_LSB  = SLOT_W'(W);
   localparam logic [ID_W-1:0]   PTR_RST   = ID_W'(N_REQ - 1);

   logic [DIV_W-1:0]  div_q, div_d;
   logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt;
   logic              bclk_q, bclk_d, lrclk_q, lrclk_d;
   logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, pid_q, pid_d;
   logic              act_q, act_d, pend_q, pend_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic              ser_a_q, ser_a_d, ser_b_q, ser_b_d;
   logic              minus_a_q, minus_a_d, minus_b_q, minus_b_d;
   logic [N_REQ-1:0]  req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [W-1:0]      rsp_data_q, rsp_data_d;
   logic              busy_q, busy_d;

   logic              tick;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   int unsigned       idx;

   assign tick     = (div_q == DIV_LAST);
   assign slot_nxt = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

   // Round-robin search starting just after the last grant.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = (32'(ptr_q) + i) % N_REQ;
         if (!gnt_found && req_valid[ID_W'(idx)]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      div_d       = tick ? '0 : div_q + 1'b1;
      slot_d      = slot_q;
      bclk_d      = bclk_q;
      lrclk_d     = lrclk_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      pid_d       = pid_q;
      act_d       = act_q;
      pend_d      = pend_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      ser_a_d     = ser_a_q;
      ser_b_d     = ser_b_q;
      minus_a_d   = minus_a_q;
      minus_b_d   = minus_b_q;
      req_ready_d = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;

      if (tick) bclk_d = ~bclk_q;

      // Falling bclk edge: next slot, frame start, serial bit shift.
      if (tick && bclk_q) begin
         slot_d  = slot_nxt;
         ser_a_d = 1'b0;
         ser_b_d = 1'b0;
         if (slot_nxt == '0) begin
            lrclk_d = ~lrclk_q;
            pend_d  = act_q;
            pid_d   = id_q;
            act_d   = gnt_found;
            if (gnt_found) begin
               req_ready_d[gnt_id] = 1'b1;
               a_d   = req_a[32'(gnt_id)*W +: W];
               b_d   = req_b[32'(gnt_id)*W +: W];
               op_d  = req_op[32'(gnt_id)*2 +: 2];
               id_d  = gnt_id;
               ptr_d = gnt_id;
            end else begin
               a_d  = '0;
               b_d  = '0;
               op_d = 2'b00;
            end
         end else if (slot_nxt <= SLOT_LSB) begin
            ser_a_d = a_q[W-1];
            ser_b_d = b_q[W-1];
            a_d     = {a_q[W-2:0], 1'b0};
            b_d     = {b_q[W-2:0], 1'b0};
            // The adder latches the old result on this edge, so minus switches only now.
            if (slot_nxt == SLOT_MSB) begin
               minus_a_d = (op_q == 2'b10);
               minus_b_d = (op_q == 2'b01);
            end
         end
      end

      // Rising bclk edge inside slot 1: previous frame's result is stable.
      if (tick && !bclk_q && slot_q == SLOT_MSB && pend_q) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = pid_q;
         rsp_data_d  = res_p;
         pend_d      = 1'b0;
      end

      busy_d = act_d | pend_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q       <= '0;
         slot_q      <= '0;
         bclk_q      <= 1'b0;
         lrclk_q     <= 1'b0;
         ptr_q       <= PTR_RST;
         id_q        <= '0;
         pid_q       <= '0;
         act_q       <= 1'b0;
         pend_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 2'b00;
         ser_a_q     <= 1'b0;
         ser_b_q     <= 1'b0;
         minus_a_q   <= 1'b0;
         minus_b_q   <= 1'b0;
         req_ready_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         div_q       <= div_d;
         slot_q      <= slot_d;
         bclk_q      <= bclk_d;
         lrclk_q     <= lrclk_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         pid_q       <= pid_d;
         act_q       <= act_d;
         pend_q      <= pend_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         ser_a_q     <= ser_a_d;
         ser_b_q     <= ser_b_d;
         minus_a_q   <= minus_a_d;
         minus_b_q   <= minus_b_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   assign bclk      = bclk_q;
   assign lrclk     = lrclk_q;
   assign ser_a     = ser_a_q;
   assign ser_b     = ser_b_q;
   assign minus_a   = minus_a_q;
   assign minus_b   = minus_b_q;
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_sum_sched.sv
// Directed bench for serial_sum_sched with a behavioural bit-serial adder on res_p.
module tb_serial_sum_sched;

   localparam int unsigned W   = 8;
   localparam int unsigned N   = 4;
   localparam int unsigned CD  = 2;
   localparam int unsigned FB  = 10;
   localparam int unsigned LAT = 46;   // (2*10+3)*2
   localparam int unsigned FRM = 40;   // 10 slots * 2 * 2 clk

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [2*N-1:0] req_op = '0;
   logic [W*N-1:0] req_a = '0;
   logic [W*N-1:0] req_b = '0;
   logic           bclk, lrclk, ser_a, ser_b, minus_a, minus_b;
   logic [W-1:0]   res_p = '0;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;
   logic           busy;

   int compared   = 0;
   int mismatched = 0;
   int stray      = 0;

   serial_sum_sched #(.W(W), .N_REQ(N), .CLK_DIV(CD), .FRAME_BITS(FB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .bclk(bclk), .lrclk(lrclk), .ser_a(ser_a), .ser_b(ser_b),
      .minus_a(minus_a), .minus_b(minus_b), .res_p(res_p),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Adder model: samples bits on bclk rise in slots 1..W, updates out_p on slot-1 entry.
   logic [W-1:0] m_sa, m_sb;
   logic         m_ma, m_mb, m_bp, m_lp, m_s1;
   int           m_cnt;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_bp = 1'b0; m_lp = 1'b0; m_s1 = 1'b0; m_cnt = W;
      end else begin
         if (!bclk && m_bp) begin
            if (lrclk != m_lp) begin
               m_s1 = 1'b1;
            end else if (m_s1) begin
               res_p = (m_ma ? W'(-m_sa) : m_sa) + (m_mb ? W'(-m_sb) : m_sb);
               m_s1  = 1'b0;
               m_cnt = 0;
            end
            m_lp = lrclk;
         end
         if (bclk && !m_bp && m_cnt < W) begin
            m_sa = {m_sa[W-2:0], ser_a};
            m_sb = {m_sb[W-2:0], ser_b};
            m_ma = minus_a;
            m_mb = minus_b;
            m_cnt++;
         end
         m_bp = bclk;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_valid[i]       = 1'b1;
      req_op[2*i +: 2]   = op;
      req_a[i*W +: W]    = a;
      req_b[i*W +: W]    = b;
   endtask

   task automatic wait_ready(input int i, input string tag);
      int n = 0;
      while (req_ready === '0 && n < 400) begin
         @(negedge clk);
         n++;
         if (rsp_valid === 1'b1) stray++;
      end
      chk(tag, 32'(req_ready), 32'(1) << i);
   endtask

   task automatic wait_rsp(input int skip, input int id, input logic [W-1:0] data,
                           input string tag);
      int n = skip;
      while (rsp_valid !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), LAT);
      chk({tag, "_id"}, 32'(rsp_id), 32'(id));
      chk({tag, "_data"}, 32'(rsp_data), 32'(data));
   endtask

   task automatic do_op(input int i, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ma, input logic mb,
                        input logic [W-1:0] exp, input string tag);
      set_req(i, op, a, b);
      wait_ready(i, {tag, "_grant"});
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      req_valid = '0;
      repeat (4) @(negedge clk);
      chk({tag, "_minus_a"}, 32'(minus_a), 32'(ma));
      chk({tag, "_minus_b"}, 32'(minus_b), 32'(mb));
      wait_rsp(4, i, exp, tag);
   endtask

   int          rr_exp [5] = '{0, 1, 2, 3, 0};
   logic [7:0]  rr_dat [5] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h01};

   initial begin
      int ng, nr, last_g, bad, tb, tl;
      logic pb, pl;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_bclk", 32'(bclk), 0);
      chk("rst_lrclk", 32'(lrclk), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ser", 32'({ser_a, ser_b, minus_a, minus_b}), 0);
      chk("rst_rsp", 32'({rsp_id, rsp_data}), 0);
      rst_n = 1'b1;

      // Single ops: add, subtract both ways, wrap-around, op 11
      do_op(0, 2'b00, 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, "add");
      do_op(1, 2'b01, 8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, "a_minus_b");
      do_op(2, 2'b10, 8'h03, 8'h10, 1'b1, 1'b0, 8'h0D, "b_minus_a");
      do_op(3, 2'b00, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, "wrap_add");

      // All requesters valid: round-robin order, one grant and one rsp per frame
      for (int i = 0; i < 4; i++) set_req(i, 2'b00, W'(8'h10 * i + 1), W'(i));
      ng = 0; nr = 0; last_g = 0;
      for (int c = 0; c < 600 && nr < 5; c++) begin
         @(negedge clk);
         if (req_ready !== '0 && ng < 5) begin
            chk("rr_grant", 32'(req_ready), 32'(1) << rr_exp[ng]);
            if (ng > 0) chk("rr_spacing", 32'(c - last_g), FRM);
            last_g = c;
            ng++;
            if (ng == 5) req_valid = '0;
         end
         if (rsp_valid === 1'b1 && nr < 5) begin
            chk("rr_rsp_id", 32'(rsp_id), 32'(rr_exp[nr]));
            chk("rr_rsp_data", 32'(rsp_data), 32'(rr_dat[nr]));
            nr++;
         end
      end
      chk("rr_rsp_count", 32'(nr), 5);

      do_op(0, 2'b01, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, "wrap_sub");
      do_op(1, 2'b11, 8'h02, 8'h03, 1'b0, 1'b0, 8'h05, "op11");

      // Idle frames: clocks keep running, everything else quiet
      bad = 0; tb = 0; tl = 0; pb = bclk; pl = lrclk;
      for (int c = 0; c < 3 * FRM; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b0) bad++;
         if ({ser_a, ser_b, minus_a, minus_b} !== 4'b0) bad++;
         if (bclk !== pb) tb++;
         if (lrclk !== pl) tl++;
         pb = bclk; pl = lrclk;
      end
      chk("idle_quiet", 32'(bad), 0);
      chk("idle_bclk_toggles", 32'(tb), 3 * FRM / CD);
      chk("idle_lrclk_toggles", 32'(tl), 3);

      // Reset mid-frame after a grant: op dropped, pointer back to N-1
      set_req(1, 2'b00, 8'h40, 8'h01);
      wait_ready(1, "pre_rst_grant");
      req_valid = '0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_clocks", 32'({bclk, lrclk}), 0);
      chk("midrst_outs", 32'({ser_a, ser_b, minus_a, minus_b, rsp_valid}), 0);
      repeat (2) @(negedge clk);
      set_req(1, 2'b00, 8'h22, 8'h11);
      set_req(3, 2'b00, 8'h77, 8'h01);
      rst_n = 1'b1;
      stray = 0;
      wait_ready(1, "post_rst_grant");
      req_valid = '0;
      chk("post_rst_no_stale_rsp", 32'(stray), 0);
      wait_rsp(0, 1, 8'h33, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_sum_sched.md
Name: serial_sum_sched

Overview:
- Scheduler and clock master for the bit-serial adder (`sum`).
- Generates `bclk`/`lrclk` and round-robin arbitrates up to N_REQ requesters, one operation per frame.
- Serializes the granted operands MSB-first onto the adder inputs and drives its `minus_a`/`minus_b` controls.
- Captures the adder's parallel result (`out_p`) one frame later and returns it, tagged with the requester id.

Parameters:
- W, 32: operand/result width; must equal the adder's w_sum.
- N_REQ, 4: number of requesters, >= 2.
- CLK_DIV, 4: clk cycles per bclk half-period, >= 2.
- FRAME_BITS, 64: bclk periods per frame (one lrclk half-period), >= W+2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-clk grant pulse; operands accepted on it
- req_op  in  2*N_REQ  per requester: 00 a+b, 01 a-b, 10 b-a, 11 treated as 00
- req_a  in  W*N_REQ  operand a per requester
- req_b  in  W*N_REQ  operand b per requester
- bclk  out  1  bit clock to adder
- lrclk  out  1  frame clock to adder
- ser_a  out  1  serial operand a (adder in_a)
- ser_b  out  1  serial operand b (adder in_b)
- minus_a  out  1  invert-a control
- minus_b  out  1  invert-b control
- res_p  in  W  adder parallel result (out_p)
- rsp_valid  out  1  one-clk result strobe
- rsp_id  out  $clog2(N_REQ)  requester owning rsp_data
- rsp_data  out  W  result (two's complement, modulo 2^W)
- busy  out  1  op issued or result pending

Behaviour:
- Reset value of all outputs is 0, including bclk/lrclk; the slot counter is 0, the RR pointer is N_REQ-1 and the pending flag is clear.
- Reset is asynchronous; reset mid-frame drops in-flight ops with no rsp.
- bclk toggles every CLK_DIV clk cycles.
- Slot counter s advances on every bclk falling edge, 0..FRAME_BITS-1, then wraps.
- Falling edge entering slot 0:
  - lrclk toggles.
  - ser_a/ser_b = 0.
  - Arbitration: the first requester with req_valid=1, searching from pointer+1 with wrap-around, gets a req_ready pulse in that same clk. Its a, b, op and id are latched and the pointer is updated.
  - If nothing is valid, the frame is idle: zeros are shifted and minus = 0.
- Falling edge entering slot 1: minus_a/minus_b take the new frame's values (01→minus_b=1, 10→minus_a=1, else both 0) and are held until the next slot-1 entry. This keeps the old minus stable while the adder latches out_p on this same edge.
- Falling edge entering slot j, 1<=j<=W: ser_a/ser_b = bit W-j of the latched operands, so the MSB goes first and each bit is sampled by the adder on the rising edge inside slot j.
- Slots W+1..FRAME_BITS-1: ser_a/ser_b = 0.
- Rising bclk edge inside slot 1, if the previous frame carried an op:
  - res_p is registered into rsp_data.
  - rsp_valid pulses for 1 clk with rsp_id = previous id.
  - There is no backpressure on the response.
- Pipelining: issue and result overlap, one op in flight plus one being serialized.
- Throughput is one op per frame.
- Latency from the req_ready clk to the rsp_valid clk is (2*FRAME_BITS+3)*CLK_DIV.
- Requesters must hold valid and operands until req_ready. Deasserting valid before grant withdraws the request.
- A requester granted this frame has lowest priority next frame.
- busy = granted op being serialized OR response pending.

Test Plan:
- W=8, FRAME_BITS=10, CLK_DIV=2; req0 op 00, a=0x05, b=0x03 → req_ready[0] at first slot-0 entry; rsp_valid 46 clks later with id 0, data 0x08.
- req1 op 01, a=0x10, b=0x03 → minus_b=1 for that frame, rsp data 0x0D. Op 10, a=0x03, b=0x10 → minus_a=1, data 0x0D.
- Wrap-around: a=0xFF, b=0x01, op 00 → data 0x00. a=0x00, b=0x01, op 01 → data 0xFF.
- All four requesters valid continuously → grants 0,1,2,3,0 in consecutive frames; rsp ids follow the same order, one per frame.
- No requests for 3 frames → bclk/lrclk keep running, ser=0, minus=0, no rsp_valid, busy=0.
- Assert rst_n=0 mid-frame after a grant → all outputs 0 immediately, no rsp for the dropped op; the first grant after release goes to the lowest valid index.
